// File: rtl/qed_pkg.sv
// Shared opcodes, FSM state, decoded-field payload and decoder for the QED duplication path.
package qed_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;

    localparam int unsigned SHADOW_BIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        EMPTY,
        ORIG,
        DUP
    } state_t;

    // Register fields plus which of them exist for the instruction's format
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             has_rd;
        logic             has_rs1;
        logic             has_rs2;
        logic             dup_able;
        logic             is_jalr;
    } qed_dec_t;

    function automatic qed_dec_t qed_decoder(input logic [ILEN-1:0] instr);
        qed_dec_t d;
        d          = '0;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        case (instr[6:0])
            OP:           begin d.has_rd = 1'b1; d.has_rs1 = 1'b1; d.has_rs2 = 1'b1; d.dup_able = 1'b1; end
            OP_IMM, LOAD: begin d.has_rd = 1'b1; d.has_rs1 = 1'b1; d.dup_able = 1'b1; end
            STORE:        begin d.has_rs1 = 1'b1; d.has_rs2 = 1'b1; d.dup_able = 1'b1; end
            LUI, AUIPC:   begin d.has_rd = 1'b1; d.dup_able = 1'b1; end
            JALR:         begin d.has_rd = 1'b1; d.has_rs1 = 1'b1; d.is_jalr = 1'b1; end
            default:      d = d;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qed_modify_instruction.sv
// Combinational register remap producing the shadow-register duplicate and its need flag.
module qed_modify_instruction
    import qed_pkg::*;
#(
    parameter int unsigned SHADOW_BIT = SHADOW_BIT_DEFAULT,
    parameter int unsigned DUP_JALR   = 0
) (
    input  logic [ILEN-1:0] instr,
    input  qed_dec_t        dec,
    input  logic            qed_en,
    output logic [ILEN-1:0] dup_instr,
    output logic            needs_dup
);

    localparam logic [REG_W-1:0] SHADOW_MASK = REG_W'(1 << SHADOW_BIT);

    // x0 is never remapped so the duplicate keeps hard-wired zero semantics
    function automatic logic [REG_W-1:0] shadow(input logic [REG_W-1:0] r);
        return (r != '0) ? (r | SHADOW_MASK) : r;
    endfunction

    always_comb begin
        dup_instr = instr;
        if (dec.has_rd)  dup_instr[11:7]  = shadow(dec.rd);
        if (dec.has_rs1) dup_instr[19:15] = shadow(dec.rs1);
        if (dec.has_rs2) dup_instr[24:20] = shadow(dec.rs2);
        needs_dup = qed_en && (dec.dup_able || (dec.is_jalr && (DUP_JALR != 0)));
    end

endmodule

// File: rtl/qed_dup_sequencer.sv
// Issues each fetched instruction and, when QED is enabled, its shadow-register duplicate.
// Optional macro QED_STATS_EN adds original/duplicate issue counters.
module qed_dup_sequencer
    import qed_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHADOW_BIT = SHADOW_BIT_DEFAULT,
    parameter int unsigned DUP_JALR   = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            qed_en_i,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [ILEN-1:0] fetch_instr_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_ready_o,
    output logic            issue_valid_o,
    output logic [ILEN-1:0] issue_instr_o,
    output logic [XLEN-1:0] issue_pc_o,
    output logic            issue_is_dup_o,
    input  logic            issue_ready_i
`ifdef QED_STATS_EN
    ,
    output logic [31:0]     stat_orig_o,
    output logic [31:0]     stat_dup_o
`endif
);

    state_t          state, state_next;
    logic            needs_dup_q, needs_dup_d;
    logic [ILEN-1:0] dup_q, dup_d;
    logic            valid_d, is_dup_d;
    logic [ILEN-1:0] instr_d;
    logic [XLEN-1:0] pc_d;

    qed_dec_t        dec;
    logic [ILEN-1:0] dup_word;
    logic            needs_dup_c;
    logic            issue_fire, last_slot, accept;

    assign dec = qed_decoder(fetch_instr_i);

    qed_modify_instruction #(
        .SHADOW_BIT (SHADOW_BIT),
        .DUP_JALR   (DUP_JALR)
    ) u_modify (
        .instr     (fetch_instr_i),
        .dec       (dec),
        .qed_en    (qed_en_i),
        .dup_instr (dup_word),
        .needs_dup (needs_dup_c)
    );

    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign last_slot     = ((state == ORIG) && !needs_dup_q) || (state == DUP);
    assign fetch_ready_o = !flush_i && ((state == EMPTY) || (issue_ready_i && last_slot));
    assign accept        = fetch_valid_i && fetch_ready_o;

    // Accept only happens from EMPTY or on the final slot, so it overrides the drain path
    always_comb begin
        state_next  = state;
        needs_dup_d = needs_dup_q;
        dup_d       = dup_q;
        valid_d     = issue_valid_o;
        instr_d     = issue_instr_o;
        pc_d        = issue_pc_o;
        is_dup_d    = issue_is_dup_o;
        if (flush_i) begin
            state_next  = EMPTY;
            valid_d     = 1'b0;
            is_dup_d    = 1'b0;
            needs_dup_d = 1'b0;
        end else if (accept) begin
            state_next  = ORIG;
            valid_d     = 1'b1;
            instr_d     = fetch_instr_i;
            pc_d        = fetch_pc_i;
            is_dup_d    = 1'b0;
            dup_d       = dup_word;
            needs_dup_d = needs_dup_c;
        end else if (issue_fire) begin
            if ((state == ORIG) && needs_dup_q) begin
                state_next = DUP;
                instr_d    = dup_q;
                is_dup_d   = 1'b1;
            end else begin
                state_next = EMPTY;
                valid_d    = 1'b0;
                is_dup_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= EMPTY;
            needs_dup_q    <= 1'b0;
            dup_q          <= '0;
            issue_valid_o  <= 1'b0;
            issue_instr_o  <= '0;
            issue_pc_o     <= '0;
            issue_is_dup_o <= 1'b0;
        end else begin
            state          <= state_next;
            needs_dup_q    <= needs_dup_d;
            dup_q          <= dup_d;
            issue_valid_o  <= valid_d;
            issue_instr_o  <= instr_d;
            issue_pc_o     <= pc_d;
            issue_is_dup_o <= is_dup_d;
        end
    end

`ifdef QED_STATS_EN
    // Completed issue handshakes; survive flush, wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_orig_o <= '0;
            stat_dup_o  <= '0;
        end else if (issue_fire) begin
            if (issue_is_dup_o) stat_dup_o  <= stat_dup_o + 32'd1;
            else                stat_orig_o <= stat_orig_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer; stats checks compile in with QED_STATS_EN.
module tb_qed_dup_sequencer;

    localparam logic [31:0] I_ADD      = 32'h002081B3;
    localparam logic [31:0] I_ADD_DUP  = 32'h012889B3;
    localparam logic [31:0] I_ADDI     = 32'h00700293;
    localparam logic [31:0] I_ADDI_DUP = 32'h00700A93;
    localparam logic [31:0] I_BEQ      = 32'h00208463;

    logic        clk = 1'b0;
    logic        rst, qed_en, flush, fetch_valid, fetch_ready;
    logic [31:0] fetch_instr, fetch_pc;
    logic        issue_valid, issue_is_dup, issue_ready;
    logic [31:0] issue_instr, issue_pc;
`ifdef QED_STATS_EN
    logic [31:0] stat_orig, stat_dup;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [31:0] adds [4];
    logic [31:0] stream [7];
    logic        got;

    always #5 clk = ~clk;

    qed_dup_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .qed_en_i       (qed_en),
        .flush_i        (flush),
        .fetch_valid_i  (fetch_valid),
        .fetch_instr_i  (fetch_instr),
        .fetch_pc_i     (fetch_pc),
        .fetch_ready_o  (fetch_ready),
        .issue_valid_o  (issue_valid),
        .issue_instr_o  (issue_instr),
        .issue_pc_o     (issue_pc),
        .issue_is_dup_o (issue_is_dup),
        .issue_ready_i  (issue_ready)
`ifdef QED_STATS_EN
        ,
        .stat_orig_o    (stat_orig),
        .stat_dup_o     (stat_dup)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic dup);
        chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
        chk({tag, "_instr"}, issue_instr, instr);
        chk({tag, "_pc"}, issue_pc, pc);
        chk({tag, "_dup"}, 32'(issue_is_dup), 32'(dup));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; qed_en = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
        fetch_instr = '0; fetch_pc = '0; issue_ready = 1'b0;
        adds[0] = 32'h002081B3; adds[1] = 32'h00208233;
        adds[2] = 32'h002082B3; adds[3] = 32'h00208333;
        stream[0] = I_ADD; stream[1] = I_BEQ; stream[2] = I_ADD; stream[3] = I_ADDI;
        stream[4] = I_BEQ; stream[5] = I_ADD; stream[6] = I_ADDI;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_instr", issue_instr, 32'd0);
        chk("rst_pc", issue_pc, 32'd0);
        chk("rst_dup", 32'(issue_is_dup), 32'd0);
        rst = 1'b0;

        // ADD original then duplicate on consecutive cycles
        qed_en = 1'b1; issue_ready = 1'b1;
        fetch_valid = 1'b1; fetch_instr = I_ADD; fetch_pc = 32'h100;
        #1 chk("add_fready_empty", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        chk_slot("add_orig", I_ADD, 32'h100, 1'b0);
        fetch_valid = 1'b0;
        #1 chk("add_fready_orig", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        chk_slot("add_dup", I_ADD_DUP, 32'h100, 1'b1);
        @(negedge clk);
        chk("add_drain", 32'(issue_valid), 32'd0);

        // ADDI keeps x0; BEQ follows back-to-back with no duplicate
        fetch_valid = 1'b1; fetch_instr = I_ADDI; fetch_pc = 32'h104;
        @(negedge clk);
        chk_slot("addi_orig", I_ADDI, 32'h104, 1'b0);
        fetch_valid = 1'b0;
        @(negedge clk);
        chk_slot("addi_dup", I_ADDI_DUP, 32'h104, 1'b1);
        fetch_valid = 1'b1; fetch_instr = I_BEQ; fetch_pc = 32'h108;
        #1 chk("beq_fready_dup", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        chk_slot("beq_orig", I_BEQ, 32'h108, 1'b0);
        fetch_valid = 1'b0;
        #1 chk("beq_fready_last", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        chk("beq_no_dup", 32'(issue_valid), 32'd0);

        // QED disabled: four ADDs at full throughput
        qed_en = 1'b0;
        fetch_valid = 1'b1; fetch_instr = adds[0]; fetch_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_slot($sformatf("stream%0d", i), adds[i], 32'h200 + 32'(4 * i), 1'b0);
            if (i < 3) begin
                fetch_instr = adds[i + 1]; fetch_pc = 32'h200 + 32'(4 * (i + 1));
            end else begin
                fetch_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_drain", 32'(issue_valid), 32'd0);

        // Stall while the duplicate is presented
        qed_en = 1'b1;
        fetch_valid = 1'b1; fetch_instr = I_ADD; fetch_pc = 32'h300;
        @(negedge clk);
        chk_slot("stall_orig", I_ADD, 32'h300, 1'b0);
        fetch_valid = 1'b0;
        @(negedge clk);
        chk_slot("stall_dup0", I_ADD_DUP, 32'h300, 1'b1);
        issue_ready = 1'b0;
        fetch_valid = 1'b1; fetch_instr = I_ADDI; fetch_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("stall_fready%0d", i), 32'(fetch_ready), 32'd0);
            @(negedge clk);
            chk_slot($sformatf("stall_hold%0d", i), I_ADD_DUP, 32'h300, 1'b1);
        end
        issue_ready = 1'b1;
        #1 chk("stall_fready_release", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        chk_slot("stall_next_orig", I_ADDI, 32'h304, 1'b0);
        fetch_valid = 1'b0;
        @(negedge clk);
        chk_slot("stall_next_dup", I_ADDI_DUP, 32'h304, 1'b1);
        @(negedge clk);
        chk("stall_drain", 32'(issue_valid), 32'd0);

        // Flush during DUP drops the duplicate and blocks fetch
        fetch_valid = 1'b1; fetch_instr = I_ADD; fetch_pc = 32'h400;
        @(negedge clk);
        chk_slot("flush_orig", I_ADD, 32'h400, 1'b0);
        fetch_valid = 1'b0;
        @(negedge clk);
        chk_slot("flush_dup", I_ADD_DUP, 32'h400, 1'b1);
        flush = 1'b1; fetch_valid = 1'b1; fetch_instr = I_BEQ; fetch_pc = 32'h404;
        #1 chk("flush_fready", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        chk("flush_valid", 32'(issue_valid), 32'd0);
        flush = 1'b0; fetch_valid = 1'b0;
        @(negedge clk);
        chk("flush_quiet", 32'(issue_valid), 32'd0);

        // Reset during ORIG clears everything
        fetch_valid = 1'b1; fetch_instr = I_ADD; fetch_pc = 32'h500;
        @(negedge clk);
        chk_slot("rstmid_orig", I_ADD, 32'h500, 1'b0);
        rst = 1'b1; fetch_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", 32'(issue_valid), 32'd0);
        chk("rstmid_instr", issue_instr, 32'd0);
        chk("rstmid_pc", issue_pc, 32'd0);
        chk("rstmid_dup", 32'(issue_is_dup), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_quiet", 32'(issue_valid), 32'd0);

`ifdef QED_STATS_EN
        // Five duplicable + two branches -> 7 originals, 5 duplicates
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stat_rst_orig", stat_orig, 32'd0);
        chk("stat_rst_dup", stat_dup, 32'd0);
        for (int k = 0; k < 7; k++) begin
            fetch_valid = 1'b1; fetch_instr = stream[k]; fetch_pc = 32'h600 + 32'(4 * k);
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                #1 if (fetch_ready) got = 1'b1;
                @(negedge clk);
            end
            chk($sformatf("stat_accept%0d", k), 32'(got), 32'd1);
        end
        fetch_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stat_orig", stat_orig, 32'd7);
        chk("stat_dup", stat_dup, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
